// File: rtl/noc_vc_input_buffer_pkg.sv
// Shared definitions for the virtual-channel router input buffer.
// Provides default mesh/payload sizing, width helpers, the flit layout
// and the arbiter state encoding used by the buffer and its FIFOs.
package noc_vc_input_buffer_pkg;

    localparam int DEF_MESH_SIDE  = 4;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_NUM_VC     = 2;

    // Coordinate width; a 1x1 mesh still carries a 1-bit field.
    function automatic int coord_width(input int side);
        int w;
        if (side > 1) w = $clog2(side);
        else          w = 1;
        return w;
    endfunction

    // VC id width; a single-VC buffer still carries a 1-bit id.
    function automatic int vc_width(input int n);
        int w;
        if (n > 1) w = $clog2(n);
        else       w = 1;
        return w;
    endfunction

    localparam int COORD_W = coord_width(DEF_MESH_SIDE);
    localparam int VC_W    = vc_width(DEF_NUM_VC);

    typedef struct packed {
        logic                      s_delta_x;
        logic                      s_delta_y;
        logic [COORD_W-1:0]        dest_x;
        logic [COORD_W-1:0]        dest_y;
        logic [DEF_DATA_WIDTH-1:0] data;
    } flit_t;

    typedef enum logic [0:0] {
        ARB_UNLOCKED = 1'b0,
        ARB_LOCKED   = 1'b1
    } arb_state_t;

endpackage

// File: rtl/noc_vc_input_buffer_if.sv
// Flit link bundle: valid, VC tag, routing fields, payload and a ready
// vector. The input side uses one ready bit per VC; the output side uses
// a single ready bit (READY_W=1).
//   master : drives valid/vc/fields, samples ready
//   slave  : samples valid/vc/fields, drives ready
interface noc_vc_input_buffer_if #(
    parameter int VC_W       = noc_vc_input_buffer_pkg::VC_W,
    parameter int COORD_W    = noc_vc_input_buffer_pkg::COORD_W,
    parameter int DATA_WIDTH = noc_vc_input_buffer_pkg::DEF_DATA_WIDTH,
    parameter int READY_W    = 1
);
    logic                  valid;
    logic [VC_W-1:0]       vc;
    logic                  s_delta_x;
    logic                  s_delta_y;
    logic [COORD_W-1:0]    dest_x;
    logic [COORD_W-1:0]    dest_y;
    logic [DATA_WIDTH-1:0] data;
    logic [READY_W-1:0]    ready;

    modport master (
        output valid, vc, s_delta_x, s_delta_y, dest_x, dest_y, data,
        input  ready
    );

    modport slave (
        input  valid, vc, s_delta_x, s_delta_y, dest_x, dest_y, data,
        output ready
    );
endinterface

// File: rtl/noc_vc_fifo.sv
// Single-channel fall-through FIFO holding one VC's flits.
// Ports: clk, rst_n (async active-low); push/pop requests (ignored when
// full/empty respectively); wr_flit in; rd_flit = current head
// (combinational read of registered storage); full, empty, count.
// DEPTH need not be a power of two: pointers wrap explicitly.
module noc_vc_fifo
    import noc_vc_input_buffer_pkg::*;
#(
    parameter int  DEPTH     = 4,
    parameter int  CNT_W     = $clog2(DEPTH + 1),
    parameter type flit_type = flit_t
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  flit_type         wr_flit,
    output flit_type         rd_flit,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    flit_type         mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             do_push_s;
    logic             do_pop_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] n;
        if (p == PTR_W'(DEPTH - 1)) n = '0;
        else                        n = p + PTR_W'(1);
        return n;
    endfunction

    assign full      = (count_r == CNT_W'(DEPTH));
    assign empty     = (count_r == CNT_W'(0));
    assign count     = count_r;
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;
    assign rd_flit   = mem_r[rd_ptr_r];

    // Storage, pointers and occupancy; reset clears all entries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= wr_flit;
                wr_ptr_r        <= ptr_inc(wr_ptr_r);
            end
            if (do_pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/noc_vc_input_buffer_sva.sv
// Checker for the input buffer: flags a flit offered to a VC that is
// already full (the flit would be dropped).
// Ports: clk, rst_n, in_drop (offered flit hits a full VC).
module noc_vc_input_buffer_sva (
    input logic clk,
    input logic rst_n,
    input logic in_drop
);
    a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n) !in_drop);
endmodule

// File: rtl/noc_vc_input_buffer.sv
// Router input-port buffer with NUM_VC virtual channels.
// Ports: clk, rst_n (async active-low); in_link (slave: flit in, ready
// is the per-VC not-full vector); out_link (master: head flit of the
// granted VC, ready is the downstream accept); vc_count (per-VC
// occupancy, packed, VC0 in the LSBs).
// A round-robin arbiter picks among non-empty VCs; once a presented
// flit stalls, the grant is locked so the output stays stable until
// that flit is accepted.
module noc_vc_input_buffer
    import noc_vc_input_buffer_pkg::*;
#(
    parameter int NUM_VC     = 2,
    parameter int DEPTH      = 4,
    parameter int MESH_SIDE  = DEF_MESH_SIDE,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                                clk,
    input  logic                                rst_n,
    noc_vc_input_buffer_if.slave                in_link,
    noc_vc_input_buffer_if.master               out_link,
    output logic [NUM_VC*$clog2(DEPTH+1)-1:0]   vc_count
);
    localparam int CW   = coord_width(MESH_SIDE);
    localparam int VCW  = vc_width(NUM_VC);
    localparam int CNTW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic                  s_delta_x;
        logic                  s_delta_y;
        logic [CW-1:0]         dest_x;
        logic [CW-1:0]         dest_y;
        logic [DATA_WIDTH-1:0] data;
    } vflit_t;

    logic [NUM_VC-1:0] full_s;
    logic [NUM_VC-1:0] empty_s;
    logic [NUM_VC-1:0] push_s;
    logic [NUM_VC-1:0] pop_s;
    vflit_t            head_s [NUM_VC];
    logic [CNTW-1:0]   cnt_s  [NUM_VC];
    vflit_t            wr_flit_s;
    vflit_t            head_sel_s;
    logic [VCW-1:0]    in_sel_s;
    logic [VCW-1:0]    grant_s;
    logic [VCW-1:0]    rr_ptr_r;
    logic [VCW-1:0]    lock_vc_r;
    arb_state_t        state_r;
    logic              out_valid_s;
    logic              xfer_s;
    logic              drop_s;

    function automatic logic [VCW-1:0] next_vc(input logic [VCW-1:0] v);
        logic [VCW-1:0] n;
        if (v == VCW'(NUM_VC - 1)) n = '0;
        else                       n = v + VCW'(1);
        return n;
    endfunction

    // With a single VC the incoming tag carries no information.
    generate
        if (NUM_VC == 1) begin : g_sel_single
            assign in_sel_s = '0;
        end else begin : g_sel_multi
            assign in_sel_s = in_link.vc;
        end
    endgenerate

    assign wr_flit_s.s_delta_x = in_link.s_delta_x;
    assign wr_flit_s.s_delta_y = in_link.s_delta_y;
    assign wr_flit_s.dest_x    = in_link.dest_x;
    assign wr_flit_s.dest_y    = in_link.dest_y;
    assign wr_flit_s.data      = in_link.data;

    // Ready depends only on stored occupancy, never on out_ready.
    assign in_link.ready = ~full_s;
    assign drop_s        = in_link.valid && full_s[in_sel_s];
    assign out_valid_s   = ~&empty_s;
    assign xfer_s        = out_valid_s && out_link.ready;

    generate
        for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
            assign push_s[v] = in_link.valid && (in_sel_s == VCW'(v)) && !full_s[v];
            assign pop_s[v]  = xfer_s && (grant_s == VCW'(v));

            noc_vc_fifo #(
                .DEPTH     (DEPTH),
                .CNT_W     (CNTW),
                .flit_type (vflit_t)
            ) u_fifo (
                .clk     (clk),
                .rst_n   (rst_n),
                .push    (push_s[v]),
                .pop     (pop_s[v]),
                .wr_flit (wr_flit_s),
                .rd_flit (head_s[v]),
                .full    (full_s[v]),
                .empty   (empty_s[v]),
                .count   (cnt_s[v])
            );

            assign vc_count[v*CNTW +: CNTW] = cnt_s[v];
        end
    endgenerate

    // Grant: locked VC while a stalled flit is pending, else first
    // non-empty VC searching upward from rr_ptr with wrap.
    always_comb begin
        int   idx;
        logic found;
        grant_s = rr_ptr_r;
        idx     = 0;
        found   = 1'b0;
        if (state_r == ARB_LOCKED) begin
            grant_s = lock_vc_r;
        end else begin
            for (int i = 0; i < NUM_VC; i++) begin
                idx = int'(rr_ptr_r) + i;
                if (idx >= NUM_VC) idx = idx - NUM_VC;
                else               idx = idx;
                if (!found && !empty_s[idx]) begin
                    grant_s = VCW'(idx);
                    found   = 1'b1;
                end else begin
                    found   = found;
                end
            end
        end
    end

    // Output mux; every field is forced to zero while nothing is presented.
    always_comb begin
        head_sel_s         = head_s[grant_s];
        out_link.valid     = 1'b0;
        out_link.vc        = '0;
        out_link.s_delta_x = 1'b0;
        out_link.s_delta_y = 1'b0;
        out_link.dest_x    = '0;
        out_link.dest_y    = '0;
        out_link.data      = '0;
        if (out_valid_s) begin
            out_link.valid     = 1'b1;
            out_link.vc        = grant_s;
            out_link.s_delta_x = head_sel_s.s_delta_x;
            out_link.s_delta_y = head_sel_s.s_delta_y;
            out_link.dest_x    = head_sel_s.dest_x;
            out_link.dest_y    = head_sel_s.dest_y;
            out_link.data      = head_sel_s.data;
        end else begin
            out_link.valid     = 1'b0;
        end
    end

    // Arbiter lock FSM and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ARB_UNLOCKED;
            lock_vc_r <= '0;
            rr_ptr_r  <= '0;
        end else begin
            case (state_r)
                ARB_UNLOCKED: begin
                    if (out_valid_s && !out_link.ready) begin
                        state_r   <= ARB_LOCKED;
                        lock_vc_r <= grant_s;
                    end
                end
                ARB_LOCKED: begin
                    if (xfer_s) begin
                        state_r <= ARB_UNLOCKED;
                    end
                end
                default: begin
                    state_r <= ARB_UNLOCKED;
                end
            endcase
            if (xfer_s) begin
                rr_ptr_r <= next_vc(grant_s);
            end
        end
    end

    noc_vc_input_buffer_sva u_sva (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_drop (drop_s)
    );

endmodule
